// File: rtl/axis_read_address_if.sv
// AXI read-address (AR) channel bundle between the burst splitter and the AXI fabric.
interface axis_read_address_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
);
   logic [ADDR_WIDTH-1:0] araddr;
   logic [LEN_WIDTH-1:0]  arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   modport master (
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready
   );
endinterface

// File: rtl/axis_read_address.sv
// Stream-read front end: takes a start address and a length in stream words, forwards the
// length to the read-data stage and splits the request into AXI INCR bursts that respect
// BURST_MAX and never cross a 4KB boundary.
//
// state | meaning
// IDLE  | waiting for a request; cfg_rdy_o follows data_cfg_rdy_i
// SETUP | size the next burst from remaining beats, BURST_MAX and the 4KB bound
// ISSUE | AR presented, held stable until axi_ar.arready
// NEXT  | burst accepted; back to IDLE when nothing remains, else size the next one
module axis_read_address #(
   parameter int CFG_DWIDTH     = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int WIDTH_RATIO    = 2,
   parameter int AXI_LEN_WIDTH  = 4,
   parameter int BURST_MAX      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CFG_DWIDTH-1:0] cfg_address_i,
   input  logic [CFG_DWIDTH-1:0] cfg_length_i,
   input  logic                  cfg_val_i,
   output logic                  cfg_rdy_o,
   output logic [CFG_DWIDTH-1:0] data_cfg_length_o,
   output logic                  data_cfg_val_o,
   input  logic                  data_cfg_rdy_i,
   axis_read_address_if.master   axi_ar
);

   localparam int BPB       = AXI_DATA_WIDTH / 8;
   localparam int BPB_SHIFT = $clog2(BPB);
   localparam int WR_SHIFT  = $clog2(WIDTH_RATIO);

   localparam logic [CFG_DWIDTH-1:0]     WR_MASK     = CFG_DWIDTH'(WIDTH_RATIO - 1);
   localparam logic [CFG_DWIDTH-1:0]     BURST_MAX_C = CFG_DWIDTH'(BURST_MAX);
   localparam logic [AXI_ADDR_WIDTH-1:0] BPB_MASK    = AXI_ADDR_WIDTH'(BPB - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      SETUP = 4'b0010,
      ISSUE = 4'b0100,
      NEXT  = 4'b1000
   } state_t;

   state_t                    state_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [CFG_DWIDTH-1:0]     remaining_q;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q;
   logic [AXI_LEN_WIDTH-1:0]  arlen_q;
   logic                      arvalid_q;

   logic                      accept;
   logic [CFG_DWIDTH-1:0]     remaining_d;
   logic [12:0]               bound_bytes;
   logic [CFG_DWIDTH-1:0]     bound_beats;
   logic [CFG_DWIDTH-1:0]     burst_d;
   logic [CFG_DWIDTH-1:0]     burst_beats;
   logic [AXI_ADDR_WIDTH-1:0] addr_inc;

   // Request handshake and length forward are combinational so the read-data stage
   // sees its config in the same cycle the request is taken.
   always_comb begin
      cfg_rdy_o         = (state_q == IDLE) && data_cfg_rdy_i && !rst;
      accept            = cfg_val_i && cfg_rdy_o;
      data_cfg_val_o    = accept && (cfg_length_i != '0);
      data_cfg_length_o = cfg_length_i;
   end

   // Beat count rounds a partial final beat up; the read-data stage drops the surplus words.
   always_comb begin
      remaining_d = (cfg_length_i >> WR_SHIFT) + CFG_DWIDTH'((cfg_length_i & WR_MASK) != '0);
   end

   // Burst size is the smallest of what is left, BURST_MAX and the beats to the next 4KB line.
   always_comb begin
      bound_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
      bound_beats = CFG_DWIDTH'(bound_bytes >> BPB_SHIFT);
      burst_d     = remaining_q;
      if (BURST_MAX_C < burst_d) burst_d = BURST_MAX_C;
      if (bound_beats < burst_d) burst_d = bound_beats;
      burst_beats = CFG_DWIDTH'(arlen_q) + CFG_DWIDTH'(1);
      addr_inc    = (AXI_ADDR_WIDTH'(arlen_q) + AXI_ADDR_WIDTH'(1)) << BPB_SHIFT;
   end

   // Sequencer: request capture, burst sizing, AR issue and bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arvalid_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept && (cfg_length_i != '0)) begin
                  addr_q      <= AXI_ADDR_WIDTH'(cfg_address_i) & ~BPB_MASK;
                  remaining_q <= remaining_d;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               araddr_q  <= addr_q;
               arlen_q   <= AXI_LEN_WIDTH'(burst_d - CFG_DWIDTH'(1));
               arvalid_q <= 1'b1;
               state_q   <= ISSUE;
            end
            ISSUE: begin
               if (axi_ar.arready) begin
                  arvalid_q   <= 1'b0;
                  addr_q      <= addr_q + addr_inc;
                  remaining_q <= remaining_q - burst_beats;
                  state_q     <= NEXT;
               end
            end
            NEXT: begin
               state_q <= (remaining_q == '0) ? IDLE : SETUP;
            end
            default: begin
               state_q   <= IDLE;
               arvalid_q <= 1'b0;
            end
         endcase
      end
   end

   // AR outputs come straight from registers; valid is also masked while reset is held.
   always_comb begin
      axi_ar.araddr  = araddr_q;
      axi_ar.arlen   = arlen_q;
      axi_ar.arsize  = 3'(BPB_SHIFT);
      axi_ar.arburst = 2'b01;
      axi_ar.arvalid = arvalid_q && !rst;
   end

endmodule

// File: tb/tb_axis_read_address.sv
// Bench for axis_read_address: directed requests with hand-computed bursts pushed into
// expectation queues; a monitor pops and compares on every AR and data_cfg handshake.
module tb_axis_read_address;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len;
   } ar_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cfg_address = '0;
   logic [31:0] cfg_length = '0;
   logic        cfg_val = 1'b0;
   logic        cfg_rdy;
   logic [31:0] data_cfg_length;
   logic        data_cfg_val;
   logic        data_cfg_rdy = 1'b1;

   int n_checks = 0;
   int n_pass = 0;

   ar_t         exp_ar[$];
   logic [31:0] exp_cfg[$];

   axis_read_address_if #(.ADDR_WIDTH(32), .LEN_WIDTH(4)) axi_ar ();

   axis_read_address #(
      .CFG_DWIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
      .WIDTH_RATIO(2), .AXI_LEN_WIDTH(4), .BURST_MAX(16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_address_i    (cfg_address),
      .cfg_length_i     (cfg_length),
      .cfg_val_i        (cfg_val),
      .cfg_rdy_o        (cfg_rdy),
      .data_cfg_length_o(data_cfg_length),
      .data_cfg_val_o   (data_cfg_val),
      .data_cfg_rdy_i   (data_cfg_rdy),
      .axi_ar           (axi_ar)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Monitor: compare every handshake against the head of its expectation queue.
   initial begin
      ar_t e;
      forever begin
         @(negedge clk);
         if (!rst && axi_ar.arvalid && axi_ar.arready) begin
            if (exp_ar.size() == 0) begin
               check("unexpected_ar", {32'h0, axi_ar.araddr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_ar.pop_front();
               check("ar_addr", {32'h0, axi_ar.araddr}, {32'h0, e.addr});
               check("ar_len", {60'h0, axi_ar.arlen}, {60'h0, e.len});
            end
         end
         if (data_cfg_val) begin
            if (exp_cfg.size() == 0) begin
               check("unexpected_data_cfg", {32'h0, data_cfg_length}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("data_cfg_length", {32'h0, data_cfg_length}, {32'h0, exp_cfg.pop_front()});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [31:0] addr, input logic [31:0] len);
      step();
      cfg_val     = 1'b1;
      cfg_address = addr;
      cfg_length  = len;
      @(negedge clk);
      check("accept_cfg_rdy", {63'h0, cfg_rdy}, 64'h1);
      step();
      cfg_val = 1'b0;
   endtask

   task automatic wait_arvalid(input int budget, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (axi_ar.arvalid) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, {63'h0, seen}, 64'h1);
   endtask

   task automatic wait_drain(input int budget, input string name);
      bit done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (exp_ar.size() == 0 && exp_cfg.size() == 0 && cfg_rdy) begin
            done = 1'b1;
            break;
         end
      end
      check(name, {63'h0, done}, 64'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      axi_ar.arready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_arvalid", {63'h0, axi_ar.arvalid}, 64'h0);
      check("rst_cfg_rdy", {63'h0, cfg_rdy}, 64'h0);
      check("rst_data_cfg_val", {63'h0, data_cfg_val}, 64'h0);
      check("rst_arsize", {61'h0, axi_ar.arsize}, 64'h3);
      check("rst_arburst", {62'h0, axi_ar.arburst}, 64'h1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("idle_cfg_rdy", {63'h0, cfg_rdy}, 64'h1);

      // 1: two full bursts
      exp_cfg.push_back(32'd64);
      exp_ar.push_back('{32'h1000, 4'd15});
      exp_ar.push_back('{32'h1080, 4'd15});
      send_req(32'h1000, 32'd64);
      wait_drain(100, "t1_drain");
      check("t1_idle_cfg_rdy", {63'h0, cfg_rdy}, 64'h1);

      // 2: 4KB crossing split at 0x2000
      exp_cfg.push_back(32'd32);
      exp_ar.push_back('{32'h1FC0, 4'd7});
      exp_ar.push_back('{32'h2000, 4'd7});
      send_req(32'h1FC0, 32'd32);
      wait_drain(100, "t2_drain");

      // 3: odd length rounds up to 3 beats; AR valid two cycles after accept
      exp_cfg.push_back(32'd5);
      exp_ar.push_back('{32'h0, 4'd2});
      send_req(32'h0, 32'd5);
      @(negedge clk);
      check("t3_setup_arvalid", {63'h0, axi_ar.arvalid}, 64'h0);
      @(negedge clk);
      check("t3_issue_arvalid", {63'h0, axi_ar.arvalid}, 64'h1);
      wait_drain(100, "t3_drain");

      // 4: backpressure on first burst of 20 beats
      axi_ar.arready = 1'b0;
      exp_cfg.push_back(32'd40);
      exp_ar.push_back('{32'h4000, 4'd15});
      exp_ar.push_back('{32'h4080, 4'd3});
      send_req(32'h4004, 32'd40);
      wait_arvalid(20, "t4_arvalid_seen");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_arvalid", {63'h0, axi_ar.arvalid}, 64'h1);
         check("t4_hold_araddr", {32'h0, axi_ar.araddr}, 64'h4000);
         check("t4_hold_arlen", {60'h0, axi_ar.arlen}, 64'hF);
      end
      step();
      axi_ar.arready = 1'b1;
      wait_drain(100, "t4_drain");

      // 5a: zero length is taken and dropped
      step();
      cfg_val     = 1'b1;
      cfg_address = 32'h5000;
      cfg_length  = 32'd0;
      @(negedge clk);
      check("t5_zero_cfg_rdy", {63'h0, cfg_rdy}, 64'h1);
      check("t5_zero_data_cfg_val", {63'h0, data_cfg_val}, 64'h0);
      step();
      cfg_val = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("t5_zero_no_ar", {63'h0, axi_ar.arvalid}, 64'h0);
      end
      check("t5_zero_idle", {63'h0, cfg_rdy}, 64'h1);

      // 5b: no accept while the read-data stage is not ready
      step();
      data_cfg_rdy = 1'b0;
      cfg_val      = 1'b1;
      cfg_address  = 32'h6000;
      cfg_length   = 32'd4;
      repeat (3) begin
         @(negedge clk);
         check("t5_blocked_cfg_rdy", {63'h0, cfg_rdy}, 64'h0);
         check("t5_blocked_data_cfg_val", {63'h0, data_cfg_val}, 64'h0);
      end
      exp_cfg.push_back(32'd4);
      exp_ar.push_back('{32'h6000, 4'd1});
      step();
      data_cfg_rdy = 1'b1;
      @(negedge clk);
      check("t5_release_cfg_rdy", {63'h0, cfg_rdy}, 64'h1);
      step();
      cfg_val = 1'b0;
      wait_drain(100, "t5_drain");

      // 6: reset during the second burst's ISSUE
      exp_cfg.push_back(32'd64);
      exp_ar.push_back('{32'h0, 4'd15});
      send_req(32'h0, 32'd64);
      begin
         bit popped = 1'b0;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_ar.size() == 0) begin
               popped = 1'b1;
               break;
            end
         end
         check("t6_first_burst", {63'h0, popped}, 64'h1);
      end
      step();
      axi_ar.arready = 1'b0;
      wait_arvalid(20, "t6_second_issue");
      check("t6_second_araddr", {32'h0, axi_ar.araddr}, 64'h80);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_arvalid", {63'h0, axi_ar.arvalid}, 64'h0);
      check("t6_rst_cfg_rdy", {63'h0, cfg_rdy}, 64'h0);
      check("t6_rst_arsize", {61'h0, axi_ar.arsize}, 64'h3);
      check("t6_rst_arburst", {62'h0, axi_ar.arburst}, 64'h1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t6_post_rst_arvalid", {63'h0, axi_ar.arvalid}, 64'h0);
      check("t6_post_rst_cfg_rdy", {63'h0, cfg_rdy}, 64'h1);
      axi_ar.arready = 1'b1;
      exp_cfg.push_back(32'd2);
      exp_ar.push_back('{32'h3000, 4'd0});
      send_req(32'h3000, 32'd2);
      wait_drain(100, "t6_drain");

      repeat (5) @(negedge clk);
      check("final_exp_ar_empty", 64'(exp_ar.size()), 64'h0);
      check("final_exp_cfg_empty", 64'(exp_cfg.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
